uart_tx_module: RTL
===================

# uart_tx_module

Byte-oriented UART transmitter (8N1, LSB first) with an internal byte FIFO and a multi-byte push port. It pairs with `uart_rx_module` on the same serial link and mirrors its bulk interface. The receiver exposes `data`/`pop`/`can_pop`; this block exposes `data`/`push`/`can_push`. It sits between the on-chip data source (e.g. FFT result packer) and the board TX pin.

## Interface

- `clk_freq`, default 50_000_000: `clk` frequency in Hz.
- `boadrate`, default 115200: line rate in baud.
- `DEPTH`, default 4: FIFO capacity in bytes. Must satisfy DEPTH ≥ N.
- `N`, default 4: maximum bytes accepted per push.
- `clk  in  1`: single clock, all logic on rising edge.
- `arstn  in  1`: reset, asynchronous, active-low.
- `data  in  [N-1:0][7:0]`: bytes to enqueue. `data[0]` is transmitted first, then `data[1]`, and so on.
- `push  in  $clog2(N+1)`: number of bytes of `data` to enqueue this cycle (0..N).
- `can_push  out  $clog2(N+1)`: bytes the FIFO will accept this cycle, equal to min(free slots, N).
- `tx  out  1`: serial line. Idles high.
- `busy  out  1`: high while a frame is on the line or the FIFO is non-empty.

## Operation

- Bit period `DIV = (clk_freq + boadrate/2) / boadrate`, i.e. rounded to nearest. With the defaults DIV = 434.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Total 10 bits.
- FIFO is circular with DEPTH entries and read/write pointers that wrap modulo DEPTH, plus an occupancy count of width $clog2(DEPTH+1).
- Enqueue rule: accepted = min(push, can_push). Accepted bytes are `data[0..accepted-1]`, written in index order. Any excess (push > can_push) is silently dropped.
- `can_push` is combinational from the registered occupancy and does not depend on `push`.
- FSM states:
  - IDLE: tx=1. If FIFO non-empty, pop head byte into shift register, clear bit timer, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles per bit, shifting right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for DIV cycles. At the end, if FIFO non-empty, pop the next byte and go directly to START (no idle gap). Otherwise go to IDLE.
- Bit timer counts 0..DIV-1. The bit ends on the cycle the timer reaches DIV-1.
- Simultaneous pop and push in the same cycle: occupancy updates as count + accepted − popped.
  - can_push was computed before the pop, so a full FIFO accepts 0 that cycle even though a slot frees.
  - Pointer and count wrap must remain consistent.
- `busy = (state != IDLE) | (count != 0)`.

## Timing

- Reset values (asserted asynchronously, effective immediately): tx=1, busy=0, state=IDLE, FIFO empty, pointers 0, can_push=min(DEPTH,N).
- Reset mid-frame: the frame is aborted, tx returns to 1 at once, and FIFO contents are discarded. After release, `arstn` is synchronised internally (2 flops) before the FSM leaves IDLE.
- Push at rising edge E0 into an empty, idle block:
  - Byte visible in FIFO after E0.
  - FSM pops it at E1.
  - tx falls after E1.
  - busy rises after E0.
- Each bit is exactly DIV clock cycles. One frame is exactly 10·DIV cycles.
- K queued bytes are transmitted in 10·DIV·K contiguous cycles.
- `can_push` rises one cycle after each pop edge.
- busy falls the cycle after the final STOP bit completes with FIFO empty. tx is already 1 at that point.

## Test plan

- Reset: hold arstn=0 for 3 clk. Required: tx=1, busy=0, can_push=4. Deassert arstn and hold push=0 for 1000 cycles; tx must stay 1.
- Single byte: push=1, data[0]=0x55.
  - tx must be low from cycle 2 for 434 cycles, then 1,0,1,0,1,0,1,0 at 434 cycles each, then high 434 cycles.
  - busy falls at cycle 2+4340.
  - Checked by a bit-sampling model at mid-bit.
- Bulk push: push=4 with data={0xF0,0xF0,0xF0,0x55} (index 3..0).
  - Required: can_push=0 the next cycle, then 4 back-to-back frames decoding 0x55,0xF0,0xF0,0xF0 in 17360 cycles with no idle gap.
  - Loop tx into a `uart_rx_module` instance; its can_pop must reach 4 with matching bytes.
- Over-push: FIFO holding 3 bytes (can_push=1), push=4 with data[0]=0xA1.
  - Only 0xA1 is enqueued. Transmitted sequence must show exactly 4 frames after the in-flight one.
- Wrap-around: 12 single-byte pushes 0x00..0x0B, each issued as soon as can_push≠0. Required: all 12 bytes transmitted in order and pointers wrap 3 times.
- Reset mid-frame: assert arstn=0 during DATA bit 3 of 0x0F with 2 bytes queued.
  - Required: tx=1 immediately, busy=0, can_push=4, and no further frames after release.

Source files
------------

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter, LSB first, fed by a circular byte FIFO that accepts up to
// N bytes per cycle. data[0] of a push is transmitted first.
module uart_tx_module #(
  parameter int clk_freq = 50_000_000,
  parameter int boadrate = 115200,
  parameter int DEPTH    = 4,
  parameter int N        = 4
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic [N-1:0][7:0]        data,
  input  logic [$clog2(N+1)-1:0]   push,
  output logic [$clog2(N+1)-1:0]   can_push,
  output logic                     tx,
  output logic                     busy
);

  localparam int DIV = (clk_freq + boadrate / 2) / boadrate;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SW  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [1:0]    rst_sync;
  logic          run_en;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  int            free_slots;
  logic [SW-1:0] accepted;
  logic          pop;
  logic [7:0]    head;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;

  // Pointer advance modulo DEPTH; operands never exceed 2*DEPTH-1.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input int step);
    int sum;
    sum = int'(ptr) + step;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PW'(sum);
  endfunction

  // NOTE: reset asserts asynchronously but releases through two flops so the FSM
  // never starts a frame off a metastable deassertion.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run_en = rst_sync[1];

  // NOTE: every output of an always_comb gets a value on every path, or a latch appears.
  always_comb begin
    free_slots = DEPTH - int'(count);
    if (free_slots > N) can_push = SW'(N);
    else                can_push = SW'(free_slots);
  end

  assign accepted = (push < can_push) ? push : can_push;
  assign head     = mem[rd_ptr];
  assign bit_end  = (timer == TW'(DIV - 1));
  assign pop      = (count != '0) &&
                    (((state == IDLE) && run_en) || ((state == STOP) && bit_end));
  assign busy     = (state != IDLE) || (count != '0);

  // NOTE: the storage array carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (i < int'(accepted)) mem[ptr_add(wr_ptr, i)] <= data[i];
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= ptr_add(wr_ptr, int'(accepted));
      if (pop) rd_ptr <= ptr_add(rd_ptr, 1);
      count <= count + CW'(accepted) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= head;
            timer <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            // Chain straight into the next start bit so queued bytes leave gap-free.
            if (pop) begin
              shift <= head;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
